multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequential, parametrised successor to the combinational control unit. Sequences one instruction at a time through fetch, decode, execute, memory and writeback. Drives instruction- and data-memory request/acknowledge handshakes with a bounded wait, and resolves branches with correct signed/unsigned compares at XLEN width. Sits between the decoder (which supplies opcode/optype/funct3) and the datapath (PC, register file, ALU muxes, memory port).

## Interface
- XLEN, 32: register/compare width (32 or 64).
- MEM_TIMEOUT, 15: maximum cycles a request may wait for ack before trapping; ≥1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  instruction_format_type  decoded opcode field (shared package type).
- optype  in  instruction_op_type  R/I/S/B/U/J class.
- funct3  in  3  funct3 field.
- instr_lo  in  2  instruction bits [1:0].
- rs1_data, rs2_data  in  XLEN  register operands.
- imem_ack, dmem_ack  in  1  memory acknowledge.
- trap_clear  in  1  leaves TRAP.
- imem_req  out  1  fetch request.
- ir_write  out  1  latch instruction register.
- dmem_req  out  1  data request.
- dmem_we  out  1  data write.
- dmem_size  out  3  funct3 of load/store.
- reg_write, mem2reg, alu_src, auipc_sel  out  1  datapath controls.
- pc_write  out  1  update PC.
- pc_sel  out  2  0 = PC+len, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR).
- pc_inc2  out  1  len = 2 (compressed) else 4.
- trap  out  1  in TRAP state.
- trap_cause  out  2  0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout.
- state  out  3  current state (debug).

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Reset → FETCH.
- FETCH: imem_req=1. When imem_ack=1, ir_write=1 that cycle → DECODE.
- DECODE: 1 cycle. An unsupported opcode/optype → TRAP, cause 1. Otherwise → EXECUTE.
- EXECUTE paths:
  - B_TYPE: evaluate branch, pc_write=1, pc_sel=1 if taken else 0 → FETCH.
  - LOAD/STORE: → MEM.
  - All others: → WRITEBACK.
  - alu_src=1 for I/S/U/J; auipc_sel=1 for AUIPC.
- Branch compares:
  - BEQ/BNE: equality.
  - BLT/BGE: $signed.
  - BLTU/BGEU: unsigned.
  - funct3 010/011 on B_TYPE → TRAP, cause 1.
- MEM: dmem_req=1, dmem_size=funct3, dmem_we=1 for stores. On dmem_ack:
  - load → WRITEBACK;
  - store → FETCH with pc_write=1, pc_sel=0.
- WRITEBACK: reg_write=1 (mem2reg=1 for loads), pc_write=1.
  - pc_sel: 2 for JALR, 1 for JAL, else 0.
  - → FETCH.
- Timeout counter: clears on entry to FETCH/MEM and increments each waiting cycle. If it reaches MEM_TIMEOUT with no ack → TRAP, cause 2 (FETCH) or 3 (MEM).
- TRAP: all requests and write enables 0, trap=1, cause held. trap_clear=1 → FETCH, cause cleared.

## Timing
- Reset values:
  - state=FETCH, trap_cause=0, counter=0.
  - All outputs 0 except imem_req=1 (Moore decode of FETCH).
- All outputs are a combinational decode of the registered state plus the inputs of that cycle. Transitions occur on the rising clk edge.
- Minimum cycles per instruction (ack in the first request cycle):
  - branch: 3;
  - ALU/U/J/JALR: 4;
  - store: 4;
  - load: 5.
- Requests stay high, with stable size/we, until ack or timeout. An ack arriving in the same cycle the counter hits MEM_TIMEOUT wins: the handshake completes and no trap is raised.
- An ack outside FETCH/MEM is ignored.
- rst_n low mid-request drops requests immediately (asynchronous) → FETCH.
- trap_clear outside TRAP has no effect.
- Counter width is $clog2(MEM_TIMEOUT+1) and saturates.

## Configuration
- RVC_EN defined: instr_lo≠2'b11 marks the instruction as compressed, latched at ir_write; pc_inc2=1 for that instruction.
- RVC_EN undefined: pc_inc2 is tied to 0; instr_lo≠2'b11 → TRAP, cause 1, in DECODE.

## Structure
- The shared `common` package holds:
  - the state enum `mc_state_t`;
  - the `trap_cause_t` enum;
  - the pc_sel encodings `PC_SEL_SEQ/BR/JALR`.
- It reuses the existing opcode/optype/funct3 constants.
- Branch comparison is one sub-module, `branch_compare` (XLEN, funct3, rs1, rs2 → taken, illegal), kept combinational.

## Test plan
- ADD, acks in the first cycle: states FETCH→DECODE→EXECUTE→WRITEBACK→FETCH. reg_write=1 in cycle 4 only; pc_write cycle 4, pc_sel=0.
- BLT with rs1=32'hFFFFFFFF, rs2=1 → taken, pc_sel=1. BLTU with the same operands → not taken, pc_sel=0. Both at cycle 3.
- LW with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, dmem_size=3'b010, we=0. Then WRITEBACK with mem2reg=1.
- dmem_ack never asserted, MEM_TIMEOUT=15 → TRAP after 15 MEM cycles with trap_cause=3. trap_clear → FETCH next cycle.
- Compressed encoding instr_lo=2'b01:
  - with RVC_EN, pc_inc2=1 at WRITEBACK;
  - without RVC_EN, TRAP cause 1.
- rst_n pulsed low while in MEM: dmem_req drops asynchronously. After release, state=FETCH, imem_req=1.

Source files
------------

// File: rtl/common.sv
// common: shared decoder encodings and multicycle control FSM types.
//   instruction_format_type : 7-bit RISC-V major opcodes handled by the core
//   instruction_op_type     : R/I/S/B/U/J instruction class from the decoder
//   F3_*                    : branch funct3 encodings
//   mc_state_t              : multicycle sequencer states
//   trap_cause_t            : trap reason reported while in TRAP
//   PC_SEL_*                : next-PC source select for the datapath
package common;
   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } instruction_format_type;

   typedef enum logic [2:0] {
      R_TYPE = 3'd0,
      I_TYPE = 3'd1,
      S_TYPE = 3'd2,
      B_TYPE = 3'd3,
      U_TYPE = 3'd4,
      J_TYPE = 3'd5
   } instruction_op_type;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } mc_state_t;

   typedef enum logic [1:0] {
      TC_NONE         = 2'd0,
      TC_ILLEGAL      = 2'd1,
      TC_IMEM_TIMEOUT = 2'd2,
      TC_DMEM_TIMEOUT = 2'd3
   } trap_cause_t;

   localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
   localparam logic [1:0] PC_SEL_BR   = 2'd1;
   localparam logic [1:0] PC_SEL_JALR = 2'd2;

   // An opcode is supported only when the decoder's class agrees with it.
   function automatic logic op_legal(input logic [6:0] op, input logic [2:0] ty);
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: return ty == I_TYPE;
         OPC_STORE:                      return ty == S_TYPE;
         OPC_BRANCH:                     return ty == B_TYPE;
         OPC_OP:                         return ty == R_TYPE;
         OPC_LUI, OPC_AUIPC:             return ty == U_TYPE;
         OPC_JAL:                        return ty == J_TYPE;
         default:                        return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational branch condition evaluation at XLEN width.
//   funct3  in  branch funct3
//   rs1/rs2 in  operands
//   taken   out branch condition holds
//   illegal out funct3 is 010/011 (no such branch)
module branch_compare
   import common::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            taken,
   output logic            illegal
);
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = rs1 == rs2;
         F3_BNE:  taken = rs1 != rs2;
         F3_BLT:  taken = $signed(rs1) < $signed(rs2);
         F3_BGE:  taken = $signed(rs1) >= $signed(rs2);
         F3_BLTU: taken = rs1 < rs2;
         F3_BGEU: taken = rs1 >= rs2;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with
// bounded memory handshakes and trap handling.
//   Inputs : opcode/optype/funct3/instr_lo from the decoder, rs1/rs2 data,
//            imem_ack/dmem_ack handshakes, trap_clear.
//   Outputs: imem_req/ir_write (fetch), dmem_req/dmem_we/dmem_size (data),
//            reg_write/mem2reg/alu_src/auipc_sel/pc_write/pc_sel/pc_inc2
//            (datapath), trap/trap_cause, state (debug).
//   Macro RVC_EN: accept compressed encodings (instr_lo != 2'b11) and
//            drive pc_inc2; without it such encodings trap as illegal.
module multicycle_control_fsm
   import common::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  instruction_format_type opcode,
   input  instruction_op_type     optype,
   input  logic [2:0]             funct3,
   input  logic [1:0]             instr_lo,
   input  logic [XLEN-1:0]        rs1_data,
   input  logic [XLEN-1:0]        rs2_data,
   input  logic                   imem_ack,
   input  logic                   dmem_ack,
   input  logic                   trap_clear,
   output logic                   imem_req,
   output logic                   ir_write,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [2:0]             dmem_size,
   output logic                   reg_write,
   output logic                   mem2reg,
   output logic                   alu_src,
   output logic                   auipc_sel,
   output logic                   pc_write,
   output logic [1:0]             pc_sel,
   output logic                   pc_inc2,
   output logic                   trap,
   output logic [1:0]             trap_cause,
   output logic [2:0]             state
);
   localparam int            CW      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT = CW'(MEM_TIMEOUT);

   mc_state_t     state_q, state_d;
   trap_cause_t   cause_q, cause_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          br_taken, br_illegal, lo_illegal, illegal;
   logic          is_branch, is_load, is_store;

   branch_compare #(.XLEN(XLEN)) u_branch_compare (
      .funct3  (funct3),
      .rs1     (rs1_data),
      .rs2     (rs2_data),
      .taken   (br_taken),
      .illegal (br_illegal)
   );

   assign is_branch = optype == B_TYPE;
   assign is_load   = opcode == OPC_LOAD;
   assign is_store  = opcode == OPC_STORE;
   assign illegal   = !op_legal(opcode, optype) || (is_branch && br_illegal) || lo_illegal;
   // Saturating so a wait can never wrap back below the timeout.
   assign cnt_inc   = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;

   assign state      = state_q;
   assign trap       = state_q == TRAP;
   assign trap_cause = cause_q;

`ifdef RVC_EN
   logic comp_q, comp_d;
   // Instruction length is captured together with the instruction register.
   assign comp_d     = (state_q == FETCH && imem_ack) ? (instr_lo != 2'b11) : comp_q;
   assign lo_illegal = 1'b0;
   assign pc_inc2    = comp_q & pc_write;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) comp_q <= 1'b0;
      else        comp_q <= comp_d;
`else
   assign lo_illegal = instr_lo != 2'b11;
   assign pc_inc2    = 1'b0;
`endif

   // The counter is zero whenever a request state is entered; it only holds
   // a nonzero value across waiting FETCH/MEM cycles.
   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      cnt_d     = '0;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      dmem_size = 3'b000;
      reg_write = 1'b0;
      mem2reg   = 1'b0;
      alu_src   = 1'b0;
      auipc_sel = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = PC_SEL_SEQ;
      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               state_d  = DECODE;
            end else if (cnt_inc == TIMEOUT) begin
               state_d = TRAP;
               cause_d = TC_IMEM_TIMEOUT;
            end else
               cnt_d = cnt_inc;
         end
         DECODE: begin
            state_d = illegal ? TRAP : EXECUTE;
            cause_d = illegal ? TC_ILLEGAL : cause_q;
         end
         EXECUTE: begin
            alu_src   = optype inside {I_TYPE, S_TYPE, U_TYPE, J_TYPE};
            auipc_sel = opcode == OPC_AUIPC;
            pc_write  = is_branch;
            pc_sel    = (is_branch && br_taken) ? PC_SEL_BR : PC_SEL_SEQ;
            state_d   = is_branch ? FETCH : (is_load || is_store) ? MEM : WRITEBACK;
         end
         MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = is_store;
            dmem_size = funct3;
            if (dmem_ack) begin
               pc_write = is_store;
               state_d  = is_store ? FETCH : WRITEBACK;
            end else if (cnt_inc == TIMEOUT) begin
               state_d = TRAP;
               cause_d = TC_DMEM_TIMEOUT;
            end else
               cnt_d = cnt_inc;
         end
         WRITEBACK: begin
            reg_write = 1'b1;
            mem2reg   = is_load;
            pc_write  = 1'b1;
            pc_sel    = (opcode == OPC_JALR) ? PC_SEL_JALR : (opcode == OPC_JAL) ? PC_SEL_BR : PC_SEL_SEQ;
            state_d   = FETCH;
         end
         TRAP: begin
            state_d = trap_clear ? FETCH : TRAP;
            cause_d = trap_clear ? TC_NONE : cause_q;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= FETCH;
         cause_q <= TC_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction stream against a
// per-instruction cycle-schedule model, plus directed literal scenarios.
module tb_multicycle_control_fsm;
   import common::*;

   localparam int XLEN = 32;
   localparam int TO   = 15;
`ifdef RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   typedef struct packed {
      logic       imem_req;
      logic       ir_write;
      logic       dmem_req;
      logic       dmem_we;
      logic [2:0] dmem_size;
      logic       reg_write;
      logic       mem2reg;
      logic       alu_src;
      logic       auipc_sel;
      logic       pc_write;
      logic [1:0] pc_sel;
      logic       pc_inc2;
      logic       trap;
      logic [1:0] trap_cause;
      logic [2:0] state;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   instruction_format_type opcode;
   instruction_op_type     optype;
   logic [2:0]      funct3;
   logic [1:0]      instr_lo;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic imem_ack, dmem_ack, trap_clear;
   logic imem_req, ir_write, dmem_req, dmem_we, reg_write, mem2reg, alu_src, auipc_sel, pc_write, pc_inc2, trap;
   logic [2:0] dmem_size, state;
   logic [1:0] pc_sel, trap_cause;
   outs_t act;

   int n_checks = 0, n_pass = 0;
   int n_cyc, n_dreq, n_rw, n_m2r, last_pc_sel, last_inc2, last_cause, last_size;

   multicycle_control_fsm #(.XLEN(XLEN), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .optype(optype), .funct3(funct3),
      .instr_lo(instr_lo), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .trap_clear(trap_clear),
      .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_size(dmem_size), .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
      .auipc_sel(auipc_sel), .pc_write(pc_write), .pc_sel(pc_sel), .pc_inc2(pc_inc2),
      .trap(trap), .trap_cause(trap_cause), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {imem_req, ir_write, dmem_req, dmem_we, dmem_size, reg_write, mem2reg,
                 alu_src, auipc_sel, pc_write, pc_sel, pc_inc2, trap, trap_cause, state};

   function automatic bit legal(input logic [6:0] op, input logic [2:0] ty);
      case (op)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: return ty == I_TYPE;
         OPC_STORE:                      return ty == S_TYPE;
         OPC_BRANCH:                     return ty == B_TYPE;
         OPC_OP:                         return ty == R_TYPE;
         OPC_LUI, OPC_AUIPC:             return ty == U_TYPE;
         OPC_JAL:                        return ty == J_TYPE;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic bit taken_of(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, want);
   endtask

   task automatic mon_clr();
      n_cyc = 0; n_dreq = 0; n_rw = 0; n_m2r = 0;
      last_pc_sel = 3; last_inc2 = 9; last_cause = 0; last_size = 9;
   endtask

   task automatic noise();
      imem_ack   = 1'($urandom);
      dmem_ack   = 1'($urandom);
      trap_clear = 1'($urandom);
   endtask

   // One clock cycle: compare all outputs at the falling edge, then advance.
   task automatic step(input outs_t e);
      @(negedge clk);
      n_cyc++;
      if (dmem_req) begin n_dreq++; last_size = int'(dmem_size); end
      if (reg_write) n_rw++;
      if (mem2reg) n_m2r++;
      if (pc_write) begin last_pc_sel = int'(pc_sel); last_inc2 = int'(pc_inc2); end
      if (trap) last_cause = int'(trap_cause);
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, e);
      @(posedge clk); #1;
   endtask

   task automatic do_trap(input logic [1:0] c);
      outs_t e;
      int n;
      e = '0; e.state = TRAP; e.trap = 1'b1; e.trap_cause = c;
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
         noise(); trap_clear = 1'b0;
         step(e);
      end
      noise(); trap_clear = 1'b1;
      step(e);
   endtask

   task automatic reset_seq(input outs_t e);
      @(negedge clk);
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL pre_reset_outputs got=%h want=%h", act, e);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_dmem_req", int'(dmem_req), 0);
      chk("arst_imem_req", int'(imem_req), 1);
      chk("arst_state", int'(state), int'(FETCH));
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      chk("post_rst_state", int'(state), int'(FETCH));
      chk("post_rst_imem_req", int'(imem_req), 1);
   endtask

   // Runs one instruction: id/dd are the ack delays (>= TO means never),
   // rk is the MEM wait cycle at which reset is pulsed (-1 for none).
   task automatic exec(input logic [6:0] op, input logic [2:0] ty, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int id, input int dd, input int rk);
      outs_t e;
      bit ill, comp, br, ld, st;
      opcode   = instruction_format_type'(op);
      optype   = instruction_op_type'(ty);
      funct3   = f3;
      instr_lo = lo;
      rs1_data = a;
      rs2_data = b;
      comp = RVC && lo != 2'b11;
      br   = ty == B_TYPE;
      ld   = op == OPC_LOAD;
      st   = op == OPC_STORE;
      ill  = !legal(op, ty) || (br && f3[2:1] == 2'b01) || (!RVC && lo != 2'b11);
      for (int k = 0; k < TO; k++) begin
         noise(); imem_ack = k == id;
         e = '0; e.state = FETCH; e.imem_req = 1'b1; e.ir_write = imem_ack;
         step(e);
         if (imem_ack) break;
         if (k + 1 == TO) begin do_trap(2'd2); return; end
      end
      noise();
      e = '0; e.state = DECODE;
      step(e);
      if (ill) begin do_trap(2'd1); return; end
      noise();
      e = '0; e.state = EXECUTE;
      e.alu_src   = ty inside {I_TYPE, S_TYPE, U_TYPE, J_TYPE};
      e.auipc_sel = op == OPC_AUIPC;
      if (br) begin
         e.pc_write = 1'b1;
         e.pc_sel   = taken_of(f3, a, b) ? 2'd1 : 2'd0;
         e.pc_inc2  = comp;
      end
      step(e);
      if (br) return;
      if (ld || st) begin
         for (int k = 0; k < TO; k++) begin
            noise(); dmem_ack = k == dd && k != rk;
            e = '0; e.state = MEM; e.dmem_req = 1'b1; e.dmem_we = st; e.dmem_size = f3;
            if (dmem_ack && st) begin e.pc_write = 1'b1; e.pc_inc2 = comp; end
            if (k == rk) begin reset_seq(e); return; end
            step(e);
            if (dmem_ack) break;
            if (k + 1 == TO) begin do_trap(2'd3); return; end
         end
         if (st) return;
      end
      noise();
      e = '0; e.state = WRITEBACK; e.reg_write = 1'b1; e.mem2reg = ld; e.pc_write = 1'b1;
      e.pc_sel  = (op == OPC_JALR) ? 2'd2 : (op == OPC_JAL) ? 2'd1 : 2'd0;
      e.pc_inc2 = comp;
      step(e);
   endtask

   logic [6:0] ops [9] = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
   logic [2:0] tys [9] = '{I_TYPE, I_TYPE, U_TYPE, S_TYPE, R_TYPE, U_TYPE, B_TYPE, I_TYPE, J_TYPE};

   function automatic int rnd_delay();
      int r;
      r = int'($urandom_range(0, 19));
      return r == 0 ? 99 : r == 1 ? TO - 1 : r < 10 ? 0 : int'($urandom_range(1, 4));
   endfunction

   initial begin
      outs_t e;
      opcode = OPC_OP; optype = R_TYPE; funct3 = 3'd0; instr_lo = 2'b11;
      rs1_data = '0; rs2_data = '0; imem_ack = 1'b0; dmem_ack = 1'b0; trap_clear = 1'b0;
      mon_clr();
      #2;
      e = '0; e.imem_req = 1'b1;
      chk("reset_outputs", int'(act), int'(e));
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      chk("reset_state", int'(state), int'(FETCH));
      chk("reset_imem_req", int'(imem_req), 1);
      chk("reset_cause", int'(trap_cause), 0);

      mon_clr();
      exec(OPC_OP, R_TYPE, 3'd0, 2'b11, 32'd5, 32'd7, 0, 0, -1);
      chk("add_cycles", n_cyc, 4);
      chk("add_reg_write_cycles", n_rw, 1);
      chk("add_pc_sel", last_pc_sel, 0);

      mon_clr();
      exec(OPC_BRANCH, B_TYPE, 3'b100, 2'b11, 32'hFFFFFFFF, 32'd1, 0, 0, -1);
      chk("blt_cycles", n_cyc, 3);
      chk("blt_pc_sel", last_pc_sel, 1);

      mon_clr();
      exec(OPC_BRANCH, B_TYPE, 3'b110, 2'b11, 32'hFFFFFFFF, 32'd1, 0, 0, -1);
      chk("bltu_cycles", n_cyc, 3);
      chk("bltu_pc_sel", last_pc_sel, 0);

      mon_clr();
      exec(OPC_LOAD, I_TYPE, 3'b010, 2'b11, 32'd0, 32'd0, 0, 3, -1);
      chk("lw_dmem_req_cycles", n_dreq, 4);
      chk("lw_dmem_size", last_size, 2);
      chk("lw_mem2reg_cycles", n_m2r, 1);
      chk("lw_cycles", n_cyc, 8);

      mon_clr();
      exec(OPC_LOAD, I_TYPE, 3'b010, 2'b11, 32'd0, 32'd0, 0, 99, -1);
      chk("timeout_dmem_req_cycles", n_dreq, TO);
      chk("timeout_cause", last_cause, 3);

      mon_clr();
      exec(OPC_OP, R_TYPE, 3'd0, 2'b01, 32'd1, 32'd2, 0, 0, -1);
`ifdef RVC_EN
      chk("rvc_pc_inc2", last_inc2, 1);
`else
      chk("rvc_illegal_cause", last_cause, 1);
`endif

      exec(OPC_LOAD, I_TYPE, 3'b010, 2'b11, 32'd0, 32'd0, 0, 5, 2);

      for (int i = 0; i < 400; i++) begin
         int idx, m;
         logic [6:0] op;
         logic [2:0] ty;
         logic [XLEN-1:0] a, b;
         idx = int'($urandom_range(0, 8));
         op = ops[idx];
         ty = tys[idx];
         if ($urandom_range(0, 15) == 0) begin op = 7'($urandom); ty = 3'($urandom); end
         m = int'($urandom_range(0, 3));
         a = XLEN'($urandom);
         b = m == 0 ? a : m == 1 ? ~a : m == 2 ? a ^ {1'b1, {(XLEN-1){1'b0}}} : XLEN'($urandom);
         exec(op, ty, 3'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11,
              a, b, rnd_delay(), rnd_delay(), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
